pokey_serout: RTL and testbench

POKEY_SEROUT -- requirements
Module: pokey_serout

---
 rtl/pokey_serout.sv | 158 +++++++++++++++
 tb/tb_pokey_serout.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pokey_serout.sv
// POKEY-style serial output: SEROUT holding register feeding an LSB-first
// shifter that frames each byte with a start bit and STOP_BITS stop bits.
module pokey_serout #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 bit_tick,
    input  logic                 brk,
    output logic                 sout,
    output logic                 need,
    output logic                 done,
    output logic                 busy
);

    localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CW = $clog2(MAX_BITS);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_holding;
    logic                 r_hfull;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_count;
    logic                 r_sout;
    logic                 r_need;
    logic                 r_done;

    state_t               w_stateNext;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic [CW-1:0]        w_countNext;
    logic                 w_transfer;
    logic                 w_frameEnd;
    logic                 w_frameBit;
    logic                 w_soutNext;

    // The holding register is only drained at a tick boundary, so a write that
    // lands on the same tick is seen next tick rather than this one.
    always_comb begin
        w_stateNext = r_state;
        w_shiftNext = r_shift;
        w_countNext = r_count;
        w_transfer  = 1'b0;
        w_frameEnd  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bit_tick && r_hfull) begin
                    w_transfer  = 1'b1;
                    w_stateNext = S_START;
                    w_shiftNext = r_holding;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    w_stateNext = S_DATA;
                    w_countNext = '0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (r_count == DATA_LAST) begin
                        w_stateNext = S_STOP;
                        w_countNext = '0;
                    end else begin
                        w_shiftNext = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_countNext = r_count + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (r_count == STOP_LAST) begin
                        w_countNext = '0;
                        if (r_hfull) begin
                            w_transfer  = 1'b1;
                            w_stateNext = S_START;
                            w_shiftNext = r_holding;
                        end else begin
                            w_stateNext = S_IDLE;
                            w_frameEnd  = 1'b1;
                        end
                    end else begin
                        w_countNext = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // sout is derived from the state being entered so the line moves on the
    // same edge that the tick advances the frame.
    always_comb begin
        w_frameBit = 1'b1;
        case (w_stateNext)
            S_START: w_frameBit = 1'b0;
            S_DATA:  w_frameBit = w_shiftNext[0];
            default: w_frameBit = 1'b1;
        endcase
        w_soutNext = brk ? 1'b0 : w_frameBit;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_state   <= S_IDLE;
            r_holding <= '0;
            r_hfull   <= 1'b0;
            r_shift   <= '0;
            r_count   <= '0;
            r_sout    <= 1'b1;
            r_need    <= 1'b0;
            r_done    <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            r_shift <= w_shiftNext;
            r_count <= w_countNext;
            r_sout  <= w_soutNext;
            r_need  <= w_transfer;

            if (wr) begin
                r_holding <= din;
            end

            if (wr) begin
                r_hfull <= 1'b1;
            end else if (w_transfer) begin
                r_hfull <= 1'b0;
            end

            // A CPU write always wins over the end-of-frame completion flag.
            if (wr) begin
                r_done <= 1'b0;
            end else if (w_frameEnd) begin
                r_done <= 1'b1;
            end
        end
    end

    assign sout = r_sout;
    assign need = r_need;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pokey_serout.sv
// Directed bench for pokey_serout: ticks every 10 clocks, outputs sampled on
// the falling edge, expected values written out by hand per frame bit.
module tb_pokey_serout;

    logic       clk;
    logic       R;
    logic       wr;
    logic [7:0] din;
    logic       bit_tick;
    logic       brk;
    logic       sout;
    logic       need;
    logic       done;
    logic       busy;

    int vectors;
    int miscompares;

    pokey_serout #(
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk      (clk),
        .R        (R),
        .wr       (wr),
        .din      (din),
        .bit_tick (bit_tick),
        .brk      (brk),
        .sout     (sout),
        .need     (need),
        .done     (done),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One clock with the given strobes, ending on the following falling edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic t);
        wr       = w;
        din      = d;
        bit_tick = t;
        @(posedge clk);
        @(negedge clk);
        wr       = 1'b0;
        bit_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // One bit period: tick, check, then nine quiet clocks and check the hold.
    task automatic tickCheck(input string tag, input logic expSout, input logic expNeed,
                             input logic expBusy);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput({tag, " sout"}, sout, expSout);
        checkOutput({tag, " need"}, need, expNeed);
        checkOutput({tag, " busy"}, busy, expBusy);
        idle(9);
        checkOutput({tag, " hold sout"}, sout, expSout);
        checkOutput({tag, " hold need"}, need, 1'b0);
    endtask

    task automatic sendBits(input string tag, input logic [7:0] data, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tickCheck($sformatf("%s bit%0d", tag, i), brk ? 1'b0 : data[i], 1'b0, 1'b1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        R           = 1'b1;
        wr          = 1'b0;
        din         = 8'h00;
        bit_tick    = 1'b0;
        brk         = 1'b0;
        @(negedge clk);
        idle(2);
        R = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst sout", sout, 1'b1);
        checkOutput("rst need", need, 1'b0);
        checkOutput("rst done", done, 1'b1);
        checkOutput("rst busy", busy, 1'b0);

        $display("[TB] single frame 0x55");
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("f55 wr clears done", done, 1'b0);
        checkOutput("f55 no tick idle", sout, 1'b1);
        idle(9);
        tickCheck("f55 start", 1'b0, 1'b1, 1'b1);
        sendBits("f55", 8'h55, 0, 7);
        tickCheck("f55 stop", 1'b1, 1'b0, 1'b1);
        checkOutput("f55 done before end", done, 1'b0);
        tickCheck("f55 end", 1'b1, 1'b0, 1'b0);
        checkOutput("f55 done", done, 1'b1);

        $display("[TB] back-to-back 0xA3 then 0x0F");
        applyStimulus(1'b1, 8'hA3, 1'b0);
        idle(9);
        tickCheck("fA3 start", 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h0F, 1'b0);
        idle(9);
        sendBits("fA3", 8'hA3, 0, 7);
        tickCheck("fA3 stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f0F start b2b", 1'b0, 1'b1, 1'b1);
        checkOutput("b2b done low", done, 1'b0);
        sendBits("f0F", 8'h0F, 0, 7);
        tickCheck("f0F stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f0F end", 1'b1, 1'b0, 1'b0);
        checkOutput("b2b done", done, 1'b1);

        $display("[TB] overwrite 0x11 with 0x22");
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        idle(8);
        tickCheck("f22 start", 1'b0, 1'b1, 1'b1);
        sendBits("f22", 8'h22, 0, 7);
        tickCheck("f22 stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f22 end", 1'b1, 1'b0, 1'b0);
        checkOutput("f22 done", done, 1'b1);
        tickCheck("f22 no second frame", 1'b1, 1'b0, 1'b0);

        $display("[TB] break during data");
        applyStimulus(1'b1, 8'h55, 1'b0);
        idle(9);
        tickCheck("brk start", 1'b0, 1'b1, 1'b1);
        sendBits("brk pre", 8'h55, 0, 1);
        brk = 1'b1;
        sendBits("brk on", 8'h55, 2, 4);
        brk = 1'b0;
        idle(1);
        checkOutput("brk release restores bit4", sout, 1'b1);
        idle(8);
        sendBits("brk post", 8'h55, 5, 7);
        tickCheck("brk stop", 1'b1, 1'b0, 1'b1);
        tickCheck("brk end", 1'b1, 1'b0, 1'b0);
        checkOutput("brk done", done, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h0F, 1'b0);
        idle(9);
        tickCheck("abort start", 1'b0, 1'b1, 1'b1);
        sendBits("abort", 8'h0F, 0, 4);
        applyStimulus(1'b1, 8'h99, 1'b0);
        R   = 1'b1;
        brk = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b1);
        R   = 1'b0;
        brk = 1'b0;
        checkOutput("abort sout", sout, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort done", done, 1'b1);
        checkOutput("abort need", need, 1'b0);
        idle(9);
        tickCheck("abort hfull cleared", 1'b1, 1'b0, 1'b0);

        $display("[TB] write coincident with stop-end tick");
        applyStimulus(1'b1, 8'h3C, 1'b0);
        idle(9);
        tickCheck("f3C start", 1'b0, 1'b1, 1'b1);
        sendBits("f3C", 8'h3C, 0, 7);
        tickCheck("f3C stop", 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h81, 1'b1);
        checkOutput("coinc done held low", done, 1'b0);
        checkOutput("coinc busy", busy, 1'b0);
        checkOutput("coinc need", need, 1'b0);
        checkOutput("coinc sout", sout, 1'b1);
        idle(9);
        tickCheck("f81 start", 1'b0, 1'b1, 1'b1);
        sendBits("f81", 8'h81, 0, 7);
        tickCheck("f81 stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f81 end", 1'b1, 1'b0, 1'b0);
        checkOutput("f81 done", done, 1'b1);

        $display("[TB] write coincident with transferring tick");
        applyStimulus(1'b1, 8'h12, 1'b0);
        idle(9);
        applyStimulus(1'b1, 8'h34, 1'b1);
        checkOutput("f12 start sout", sout, 1'b0);
        checkOutput("f12 start need", need, 1'b1);
        idle(9);
        sendBits("f12", 8'h12, 0, 7);
        tickCheck("f12 stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f34 start b2b", 1'b0, 1'b1, 1'b1);
        sendBits("f34", 8'h34, 0, 7);
        tickCheck("f34 stop", 1'b1, 1'b0, 1'b1);
        tickCheck("f34 end", 1'b1, 1'b0, 1'b0);
        checkOutput("f34 done", done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
